// File: rtl/lockpick_pkg.sv
// Shared types and constants for the lockpick vault: FSM states, status codes,
// result messages and the 128-entry substitution table used by the Feistel round.
package lockpick_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_HASH,
        ST_COMPARE,
        ST_OUTPUT,
        ST_LOCKED
    } state_t;

    localparam logic [1:0] STATUS_IDLE   = 2'b00;
    localparam logic [1:0] STATUS_WRONG  = 2'b01;
    localparam logic [1:0] STATUS_WIN    = 2'b10;
    localparam logic [1:0] STATUS_LOCKED = 2'b11;

    localparam logic [127:0] MSG_WIN   = {8{16'hFACE}};
    localparam logic [127:0] MSG_WRONG = {8{16'hBAD0}};
    localparam logic [127:0] MSG_LOCK  = {8{16'hDEAD}};

    // First half of the AES S-box; the round indexes it with the low 7 bits of each byte.
    localparam logic [7:0] SBOX [128] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2
    };

    function automatic logic [7:0] sbox_lookup(input logic [6:0] idx);
        return SBOX[idx];
    endfunction

    function automatic logic [7:0] msg_byte(input logic [1:0] code, input logic [3:0] idx);
        logic [127:0] msg;
        case (code)
            STATUS_WIN:    msg = MSG_WIN;
            STATUS_LOCKED: msg = MSG_LOCK;
            default:       msg = MSG_WRONG;
        endcase
        return msg[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lockpick_feistel_round.sv
// One combinational Feistel round over the 128-bit hash state {A,B,C,D}.
module lockpick_feistel_round
    import lockpick_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    logic [31:0] a, b, c, d;
    logic [31:0] f_mix, f_rot, f_word, f_sub;
    logic [31:0] a_x, b_r, c_n, d_n;

    always_comb begin
        a = state_in[127:96];
        b = state_in[95:64];
        c = state_in[63:32];
        d = state_in[31:0];

        f_mix = ((b ^ d) + (a | c)) ^ {c[15:0], d[15:0]};

        f_rot = '0;
        f_sub = '0;
        for (int i = 0; i < 4; i++) begin
            f_rot[8*i +: 8] = {f_mix[8*i +: 7], f_mix[8*i+7]};
        end
        f_word = {f_rot[28:0], f_rot[31:29]};
        for (int i = 0; i < 4; i++) begin
            f_sub[8*i +: 8] = sbox_lookup(f_word[8*i +: 7]);
        end

        // Updates are sequential: C uses the new A, D uses the rotated B.
        a_x = a ^ f_sub;
        b_r = {b[14:0], b[31:15]};
        c_n = c + a_x;
        d_n = ~d ^ b_r;

        state_out = {a_x[23:0], a_x[31:24], b_r, c_n, d_n};
    end

endmodule

// File: rtl/lockpick_vault.sv
// Lockpick challenge engine: key load, fold, iterative Feistel hash, compare, result stream.
// Optional lockout cooldown state is enabled by defining LOCKPICK_COOLDOWN_EN.
module lockpick_vault
    import lockpick_pkg::*;
#(
    parameter int           KEY_BYTES       = 16,
    parameter int           ROUNDS          = 3,
    parameter int           MAX_ATTEMPTS    = 3,
    parameter logic [127:0] TARGET          = 128'hCAFEBABE_12345678_DEADBEEF_FEEDFACE,
    parameter int           COOLDOWN_CYCLES = 1024
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       input_enable,
    input  logic [7:0] input_data,
    input  logic       output_ready,
    output logic       output_valid,
    output logic [7:0] output_data,
    output logic [1:0] status,
    output logic [2:0] attempts_left
);

    localparam int         KEY_W         = KEY_BYTES * 8;
    localparam int         LANES         = KEY_BYTES / 16;
    localparam logic [5:0] LAST_KEY_BYTE = 6'(KEY_BYTES - 1);
    localparam logic [5:0] LAST_MSG_BYTE = 6'd15;
    localparam logic [3:0] ROUNDS_INIT   = 4'(ROUNDS);
    localparam logic [2:0] MAX_ATT       = 3'(MAX_ATTEMPTS);

    state_t           state;
    logic [5:0]       byte_cnt;
    logic [3:0]       round_cnt;
    logic [2:0]       fails;
    logic [2:0]       fails_inc;
    logic [KEY_W-1:0] key_a;
    logic [KEY_W-1:0] key_b;
    logic [KEY_W-1:0] key_b_next;
    logic [KEY_W-1:0] key_x;
    logic [127:0]     fold;
    logic [127:0]     hash;
    logic [127:0]     hash_next;

`ifdef LOCKPICK_COOLDOWN_EN
    localparam int             COOL_W    = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN_CYCLES);
    logic [COOL_W-1:0] cool_cnt;
`endif

    assign fails_inc = fails + 3'd1;

    // The fold must include the byte being accepted this cycle, so it is taken from key_b_next.
    always_comb begin
        key_b_next = key_b;
        key_b_next[{byte_cnt, 3'b000} +: 8] = input_data;
        key_x = key_a ^ key_b_next;
        fold  = '0;
        for (int l = 0; l < LANES; l++) begin
            fold = fold ^ key_x[128*l +: 128];
        end
    end

    lockpick_feistel_round u_round (
        .state_in  (hash),
        .state_out (hash_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            byte_cnt      <= '0;
            round_cnt     <= '0;
            fails         <= '0;
            key_a         <= '0;
            key_b         <= '0;
            hash          <= '0;
            status        <= STATUS_IDLE;
            attempts_left <= MAX_ATT;
            output_valid  <= 1'b0;
            output_data   <= '0;
`ifdef LOCKPICK_COOLDOWN_EN
            cool_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_LOAD_A;
                        byte_cnt      <= '0;
                        fails         <= '0;
                        status        <= STATUS_IDLE;
                        attempts_left <= MAX_ATT;
                    end
                end

                ST_LOAD_A: begin
                    if (input_enable) begin
                        key_a[{byte_cnt, 3'b000} +: 8] <= input_data;
                        if (byte_cnt == LAST_KEY_BYTE) begin
                            state    <= ST_LOAD_B;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end

                ST_LOAD_B: begin
                    if (input_enable) begin
                        key_b <= key_b_next;
                        if (byte_cnt == LAST_KEY_BYTE) begin
                            state     <= ST_HASH;
                            byte_cnt  <= '0;
                            hash      <= fold;
                            round_cnt <= ROUNDS_INIT;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end

                ST_HASH: begin
                    hash      <= hash_next;
                    round_cnt <= round_cnt - 4'd1;
                    if (round_cnt == 4'd1) begin
                        state <= ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    state        <= ST_OUTPUT;
                    byte_cnt     <= '0;
                    output_valid <= 1'b1;
                    if (hash == TARGET) begin
                        status      <= STATUS_WIN;
                        output_data <= msg_byte(STATUS_WIN, 4'd0);
                    end else if (fails_inc == MAX_ATT) begin
                        fails         <= fails_inc;
                        status        <= STATUS_LOCKED;
                        attempts_left <= 3'd0;
                        output_data   <= msg_byte(STATUS_LOCKED, 4'd0);
                    end else begin
                        fails         <= fails_inc;
                        status        <= STATUS_WRONG;
                        attempts_left <= MAX_ATT - fails_inc;
                        output_data   <= msg_byte(STATUS_WRONG, 4'd0);
                    end
                end

                ST_OUTPUT: begin
                    if (output_ready) begin
                        if (byte_cnt == LAST_MSG_BYTE) begin
                            output_valid <= 1'b0;
                            output_data  <= '0;
                            byte_cnt     <= '0;
                            if (status == STATUS_WRONG) begin
                                state <= ST_LOAD_A;
                            end else if (status == STATUS_LOCKED) begin
`ifdef LOCKPICK_COOLDOWN_EN
                                state    <= ST_LOCKED;
                                cool_cnt <= COOL_INIT;
`else
                                state <= ST_IDLE;
`endif
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            byte_cnt    <= byte_cnt + 6'd1;
                            output_data <= msg_byte(status, byte_cnt[3:0] + 4'd1);
                        end
                    end
                end

`ifdef LOCKPICK_COOLDOWN_EN
                ST_LOCKED: begin
                    cool_cnt <= cool_cnt - 1'b1;
                    if (cool_cnt <= COOL_W'(1)) begin
                        state <= ST_IDLE;
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lockpick_vault.sv
// Scoreboard bench for lockpick_vault: a 16-byte/3-round instance whose TARGET is the
// hash of an all-zero fold, and a 32-byte/5-round instance checked against a hash model.
`timescale 1ns/1ps
module tb_lockpick_vault;
    import lockpick_pkg::*;

    localparam logic [1023:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2
    };

    function automatic logic [7:0] tb_sbox(input logic [6:0] v);
        return TB_SBOX[1023 - 8*int'(v) -: 8];
    endfunction

    function automatic logic [127:0] model_round(input logic [127:0] h);
        logic [31:0] a, b, c, d, f, t;
        a = h[127:96];
        b = h[95:64];
        c = h[63:32];
        d = h[31:0];
        f = ((b ^ d) + (a | c)) ^ {c[15:0], d[15:0]};
        t = ((f << 1) & 32'hFEFEFEFE) | ((f >> 7) & 32'h01010101);
        t = (t << 3) | (t >> 29);
        f = {tb_sbox(t[30:24]), tb_sbox(t[22:16]), tb_sbox(t[14:8]), tb_sbox(t[6:0])};
        a = a ^ f;
        b = (b << 17) | (b >> 15);
        c = c + a;
        d = ~d ^ b;
        a = (a << 8) | (a >> 24);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] model_hash(input logic [127:0] fold, input int rounds);
        logic [127:0] h;
        h = fold;
        for (int r = 0; r < rounds; r++) h = model_round(h);
        return h;
    endfunction

    localparam logic [127:0] TGT16 = model_hash(128'h0, 3);

`ifdef LOCKPICK_COOLDOWN_EN
    localparam int EXP_LOCK_WAIT = 9;
`else
    localparam int EXP_LOCK_WAIT = 1;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] st;
        logic [2:0] att;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start = 1'b0, in_en = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] status;
    logic [2:0] att;

    logic       w_start = 1'b0, w_in_en = 1'b0, w_out_ready = 1'b1;
    logic [7:0] w_in_data = 8'h00;
    logic       w_out_valid;
    logic [7:0] w_out_data;
    logic [1:0] w_status;
    logic [2:0] w_att;

    exp_t q16[$];
    exp_t q32[$];
    exp_t e16, e32;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lockpick_vault #(
        .KEY_BYTES(16), .ROUNDS(3), .MAX_ATTEMPTS(3), .TARGET(TGT16), .COOLDOWN_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .input_enable(in_en), .input_data(in_data),
        .output_ready(out_ready), .output_valid(out_valid), .output_data(out_data),
        .status(status), .attempts_left(att)
    );

    lockpick_vault #(
        .KEY_BYTES(32), .ROUNDS(5), .MAX_ATTEMPTS(3), .COOLDOWN_CYCLES(8)
    ) dut32 (
        .clk(clk), .rst_n(rst_n), .start(w_start), .input_enable(w_in_en), .input_data(w_in_data),
        .output_ready(w_out_ready), .output_valid(w_out_valid), .output_data(w_out_data),
        .status(w_status), .attempts_left(w_att)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                check("dut16_unexpected_byte", 128'(out_data), 128'(9'h100));
            end else begin
                e16 = q16.pop_front();
                check("dut16_byte", 128'({out_data, status, att}), 128'(e16));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && w_out_valid && w_out_ready) begin
            if (q32.size() == 0) begin
                check("dut32_unexpected_byte", 128'(w_out_data), 128'(9'h100));
            end else begin
                e32 = q32.pop_front();
                check("dut32_byte", 128'({w_out_data, w_status, w_att}), 128'(e32));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg(input bit wide, input logic [1:0] st, input logic [2:0] at);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            case (st)
                2'b10:   d = (i % 2 == 1) ? 8'hFA : 8'hCE;
                2'b11:   d = (i % 2 == 1) ? 8'hDE : 8'hAD;
                default: d = (i % 2 == 1) ? 8'hBA : 8'hD0;
            endcase
            if (wide) q32.push_back({d, st, at});
            else      q16.push_back({d, st, at});
        end
    endtask

    // start with input_enable also high: the byte on the bus must not be captured.
    task automatic do_start();
        start   = 1'b1;
        in_en   = 1'b1;
        in_data = 8'h55;
        tick();
        start = 1'b0;
        in_en = 1'b0;
    endtask

    task automatic feed16(input logic [127:0] ka, input logic [127:0] kb);
        for (int i = 0; i < 16; i++) begin
            in_en = 1'b1; in_data = ka[8*i +: 8]; tick();
        end
        for (int i = 0; i < 16; i++) begin
            in_en = 1'b1; in_data = kb[8*i +: 8]; tick();
        end
        in_en = 1'b0;
    endtask

    task automatic wait_valid16(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check(name, 128'(n), 128'(exp_lat));
    endtask

    task automatic drain16(input string name);
        int n;
        n = 0;
        while (q16.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check(name, 128'(q16.size()), 128'(0));
    endtask

    initial begin : stim
        logic [127:0] kw, kx, ky;
        logic [255:0] ka32, kb32;
        logic [127:0] f32, m32;
        int n;

        kw = 128'h0123456789ABCDEF_FEDCBA9876543210;
        for (int i = 0; i < 16; i++) begin
            kx[8*i +: 8] = 8'(i);
            ky[8*i +: 8] = 8'(i + 17);
        end

        // Reset values
        repeat (2) tick();
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_status", 128'(status), 128'(0));
        check("rst_attempts", 128'(att), 128'(3));
        rst_n = 1'b1;
        tick();

        // Winning game: equal keys fold to zero
        do_start();
        push_msg(1'b0, 2'b10, 3'd3);
        feed16(kw, kw);
        wait_valid16("win_latency", 4);
        drain16("win_drain");
        check("win_idle_state", 128'(dut.state), 128'(ST_IDLE));
        check("win_idle_status", 128'(status), 128'(2'b10));
        check("win_idle_data", 128'({out_valid, out_data}), 128'(0));

        // Three wrong attempts ending in lockout
        do_start();
        push_msg(1'b0, 2'b01, 3'd2);
        feed16(kx, ky);
        drain16("wrong1_drain");
        check("wrong1_state", 128'(dut.state), 128'(ST_LOAD_A));
        push_msg(1'b0, 2'b01, 3'd1);
        feed16(ky, kx);
        drain16("wrong2_drain");
        push_msg(1'b0, 2'b11, 3'd0);
        feed16(kx, kw);
        drain16("lock_drain");
        check("lock_status", 128'(status), 128'(2'b11));

        start = 1'b1;
        n = 0;
        while (dut.state != ST_LOAD_A && n < 40) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("lock_start_wait", 128'(n), 128'(EXP_LOCK_WAIT));
        check("restart_attempts", 128'(att), 128'(3));
        check("restart_status", 128'(status), 128'(0));

        // Backpressure at byte 4
        push_msg(1'b0, 2'b10, 3'd3);
        out_ready = 1'b0;
        feed16(kw, kw);
        wait_valid16("bp_latency", 4);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_data", 128'(out_data), 128'(8'hCE));
            check("stall_valid", 128'(out_valid), 128'(1));
            tick();
        end
        out_ready = 1'b1;
        drain16("bp_drain");

        // Reset during HASH
        do_start();
        push_msg(1'b0, 2'b01, 3'd2);
        feed16(ky, kw);
        drain16("pre_rst_drain");
        feed16(kw, kw);
        tick();
        rst_n = 1'b0;
        #2;
        check("midrst_valid", 128'(out_valid), 128'(0));
        check("midrst_data", 128'(out_data), 128'(0));
        check("midrst_status", 128'(status), 128'(0));
        check("midrst_attempts", 128'(att), 128'(3));
        check("midrst_state", 128'(dut.state), 128'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        push_msg(1'b0, 2'b10, 3'd3);
        feed16(kw, kw);
        wait_valid16("post_rst_latency", 4);
        drain16("post_rst_drain");

        // 32-byte keys, 5 rounds
        for (int i = 0; i < 8; i++) begin
            ka32[32*i +: 32] = $urandom;
            kb32[32*i +: 32] = $urandom;
        end
        f32 = ka32[127:0] ^ ka32[255:128] ^ kb32[127:0] ^ kb32[255:128];
        m32 = model_hash(f32, 5);
        w_start = 1'b1;
        w_in_en = 1'b1;
        tick();
        w_start = 1'b0;
        push_msg(1'b1, 2'b01, 3'd2);
        for (int i = 0; i < 32; i++) begin
            w_in_data = ka32[8*i +: 8]; tick();
        end
        for (int i = 0; i < 32; i++) begin
            w_in_data = kb32[8*i +: 8]; tick();
        end
        w_in_en = 1'b0;
        n = 0;
        while (!w_out_valid && n < 60) begin
            tick();
            n++;
        end
        check("w32_latency", 128'(n), 128'(6));
        check("w32_hash", dut32.hash, m32);
        n = 0;
        while (q32.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("w32_drain", 128'(q32.size()), 128'(0));

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
